mole_game_core: RTL and testbench
=================================

# mole_game_core

Parametrised whack-a-mole game engine. It generates pseudo-random mole positions, times each mole and the whole game, detects hits from toggle switches, and keeps a saturating score. It replaces the fixed 16-switch, 20-second game block under the board top level. It drives the LED bank directly and feeds score and time-left to the BCD/seven-segment display path.

## Interface
Parameters:
- NUM_MOLES, 16: number of switch/LED pairs, range 2..32.
- CLK_HZ, 100_000_000: clock frequency in Hz.
- GAME_SECONDS, 20: game length in seconds, range 1..99.
- MOLE_MS, 800: how long a mole stays lit.
- GAP_MS, 200: dark gap between moles.
- SCORE_MAX, 99: score saturation value; must be ≤ 2^SCORE_W−1.
- SCORE_W, 7: score width in bits.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: start request, level input. A 0→1 edge is acted on.
- sw, in, NUM_MOLES: asynchronous toggle switches.
- led, out, NUM_MOLES: mole display.
- score, out, SCORE_W: hit count.
- time_left, out, $clog2(GAME_SECONDS+1): seconds remaining.
- hit_pulse, out, 1: one-cycle strobe on a scored hit.
- game_over, out, 1: high while in OVER.

## Operation
Input conditioning:
- sw and start each pass through a 2-flop synchroniser.
- A switch event is any bit of the synchronised sw differing from its value registered the previous cycle. Either toggle direction counts.

Random source:
- 16-bit maximal Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset.
- Advances every clk cycle, so player timing supplies the randomness.

FSM states: IDLE, GAP, SHOW, OVER.
- IDLE:
  - led=0, time_left=GAME_SECONDS, score held.
  - start edge → clear score, clear tick counters → GAP.
- GAP:
  - led=0.
  - After GAP_TICKS=CLK_HZ/1000×GAP_MS cycles: pick idx = lfsr mod NUM_MOLES.
  - If idx equals the previous mole, use (idx+1) mod NUM_MOLES.
  - → SHOW.
- SHOW:
  - led = one-hot(idx).
  - Event on bit idx → score+1 (saturating at SCORE_MAX), hit_pulse=1 → GAP.
  - After MOLE_TICKS=CLK_HZ/1000×MOLE_MS cycles with no hit → GAP (miss, score unchanged).
- OVER:
  - led=0, game_over=1, score held.
  - start edge → new game, same as from IDLE.

Game timer:
- In GAP/SHOW, a 1 Hz tick (CLK_HZ cycles) decrements time_left.
- Transition 1→0 → OVER.

Boundary rules:
- Hit and final second on the same cycle: the hit is scored, then the FSM goes to OVER.
- Several switch events in one cycle: a hit if bit idx is among them. Other bits follow the penalty rule only if it is enabled.
- Switch events in IDLE/GAP/OVER are ignored.
- start edge during GAP/SHOW is ignored.
- Score already at SCORE_MAX: a hit still pulses hit_pulse, score stays.
- reset asserted mid-game: returns to IDLE immediately; all counters, score and LFSR reinitialise.

## Timing
- Reset values: led=0, score=0, time_left=GAME_SECONDS, hit_pulse=0, game_over=0, state IDLE.
- All outputs are registered.
- Latency:
  - sw pin change → hit_pulse/score update: 3 clk cycles (2 sync + 1 edge register).
  - start pin edge → leaving IDLE: 3 cycles.
- SHOW exit on a hit: led goes dark the same cycle score updates.
- A mole is lit for exactly MOLE_TICKS cycles when not hit.
- time_left decrements exactly every CLK_HZ cycles after game start. The second counter is not reset between moles.

## Configuration
- MOLE_MISS_PENALTY_EN defined:
  - In SHOW, an event only on non-lit bits decrements score, saturating at 0.
  - The FSM stays in SHOW.
  - hit_pulse stays low.
- Undefined: wrong-switch events are ignored. No penalty logic is synthesised.

## Structure
- Package mole_game_pkg holds:
  - FSM state enum (IDLE, GAP, SHOW, OVER).
  - LFSR seed and tap constant.
  - ms-to-ticks helper function.
- One sub-module, mole_lfsr: 16-bit LFSR with enable and async active-low reset. It is instantiated once.
- Tick counters and the FSM stay in mole_game_core.

## Test plan
Bench parameters: CLK_HZ=1000, MOLE_MS=100, GAP_MS=20, GAME_SECONDS=3.
- Reset then start edge: state GAP, led=0 for 20 cycles, then exactly one led bit high; time_left=3.
- Toggle the lit switch 10 cycles into SHOW: hit_pulse high for 1 cycle 3 cycles later, score=1, led=0 the same cycle.
- No switch activity: each mole lit exactly 100 cycles. time_left reaches 0 at cycle 3000 after start; game_over=1, score=0.
- Hit coinciding with the final-second cycle: score increments and game_over asserts the next cycle. With GAME_SECONDS=99 and SCORE_MAX=5, the sixth hit pulses hit_pulse with score held at 5.
- Toggle a non-lit switch in SHOW:
  - Without MOLE_MISS_PENALTY_EN: score unchanged.
  - With it and score=2: score=1. Repeating at score=0 leaves 0.
- Drop reset mid-SHOW with score=2: led=0, score=0, time_left=3, state IDLE. After release, consecutive moles are never the same index over 200 moles.

Source files
------------

// File: rtl/mole_game_pkg.sv
// rtl/mole_game_pkg.sv - shared types and constants for the whack-a-mole engine
//
// Purpose: FSM state encoding, LFSR seed/tap constants and the ms-to-ticks
// conversion used by mole_game_core and mole_lfsr.
// Ports: none (package).
package mole_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int ms_to_ticks(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// rtl/mole_lfsr.sv - 16-bit maximal-length Galois LFSR
//
// Purpose: free-running pseudo-random source for mole selection.
// Ports:
//   clk   in  1   system clock
//   rst_n in  1   asynchronous active-low reset, loads LFSR_SEED
//   en    in  1   advance one step per cycle when high
//   value out 16  current LFSR state
module mole_lfsr
  import mole_game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else if (en) begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/mole_game_core.sv
// rtl/mole_game_core.sv - whack-a-mole game engine: mole timing, hit detection, score
//
// Purpose: picks pseudo-random moles, times each mole and the whole game,
// detects hits from toggle switches and keeps a saturating score.
// Optional feature macro: MOLE_MISS_PENALTY_EN (wrong-switch events in SHOW
// decrement the score, saturating at 0).
// Ports:
//   clk       in  1          system clock
//   reset     in  1          asynchronous active-low reset
//   start     in  1          start request level; a 0->1 edge starts a game
//   sw        in  NUM_MOLES  asynchronous toggle switches
//   led       out NUM_MOLES  mole display (one-hot while a mole is shown)
//   score     out SCORE_W    saturating hit count
//   time_left out clog2(GAME_SECONDS+1)  seconds remaining
//   hit_pulse out 1          one-cycle strobe on a scored hit
//   game_over out 1          high while the game is over
module mole_game_core
  import mole_game_pkg::*;
#(
  parameter int NUM_MOLES    = 16,
  parameter int CLK_HZ       = 100_000_000,
  parameter int GAME_SECONDS = 20,
  parameter int MOLE_MS      = 800,
  parameter int GAP_MS       = 200,
  parameter int SCORE_MAX    = 99,
  parameter int SCORE_W      = 7
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [NUM_MOLES-1:0]                sw,
  output logic [NUM_MOLES-1:0]                led,
  output logic [SCORE_W-1:0]                  score,
  output logic [$clog2(GAME_SECONDS+1)-1:0]   time_left,
  output logic                                hit_pulse,
  output logic                                game_over
);

  localparam int IDX_W = $clog2(NUM_MOLES);
  localparam int TL_W  = $clog2(GAME_SECONDS + 1);
  localparam logic [31:0] GAP_TICKS  = 32'(ms_to_ticks(CLK_HZ, GAP_MS));
  localparam logic [31:0] MOLE_TICKS = 32'(ms_to_ticks(CLK_HZ, MOLE_MS));
  localparam logic [31:0] SEC_TICKS  = 32'(CLK_HZ);
  localparam logic [SCORE_W-1:0]   SCORE_TOP = SCORE_W'(SCORE_MAX);
  localparam logic [TL_W-1:0]      TIME_INIT = TL_W'(GAME_SECONDS);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_MOLES - 1);
  localparam logic [NUM_MOLES-1:0] ONE_HOT0  = NUM_MOLES'(1);

  // Input conditioning: two-flop synchronisers plus a previous-value register
  // for edge/event detection.
  logic [NUM_MOLES-1:0] sw_meta, sw_sync, sw_prev;
  logic                 start_meta, start_sync, start_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta    <= '0;
      sw_sync    <= '0;
      sw_prev    <= '0;
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      sw_meta    <= sw;
      sw_sync    <= sw_meta;
      sw_prev    <= sw_sync;
      start_meta <= start;
      start_sync <= start_meta;
      start_prev <= start_sync;
    end
  end

  logic [NUM_MOLES-1:0] sw_evt;
  logic                 start_edge;
  assign sw_evt     = sw_sync ^ sw_prev;
  assign start_edge = start_sync & ~start_prev;

  // Free-running random source; player timing decides which value is sampled.
  logic [15:0] lfsr_value;
  mole_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (reset),
    .en    (1'b1),
    .value (lfsr_value)
  );

  state_t               state, state_nx;
  logic [31:0]          phase_cnt, phase_nx;
  logic [31:0]          sec_cnt, sec_nx;
  logic [IDX_W-1:0]     cur_idx, idx_nx;
  logic                 has_prev, has_prev_nx;
  logic [SCORE_W-1:0]   score_nx;
  logic [TL_W-1:0]      time_nx;
  logic                 hit_nx;
  logic                 last_sec;
  logic [NUM_MOLES-1:0] led_nx;
  logic [IDX_W-1:0]     pick_raw, pick;

  // Never show the same mole twice in a row: bump a repeat to the next index.
  assign pick_raw = IDX_W'(lfsr_value % 16'(NUM_MOLES));
  assign pick     = (has_prev && (pick_raw == cur_idx))
                    ? ((pick_raw == LAST_IDX) ? '0 : pick_raw + 1'b1)
                    : pick_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    phase_nx    = phase_cnt;
    sec_nx      = sec_cnt;
    idx_nx      = cur_idx;
    has_prev_nx = has_prev;
    score_nx    = score;
    time_nx     = time_left;
    hit_nx      = 1'b0;
    last_sec    = 1'b0;

    // The second counter runs across moles; only a game start clears it.
    if (state == GAP || state == SHOW) begin
      if (sec_cnt == SEC_TICKS - 32'd1) begin
        sec_nx   = '0;
        time_nx  = time_left - 1'b1;
        last_sec = (time_left == TL_W'(1));
      end else begin
        sec_nx = sec_cnt + 32'd1;
      end
    end

    case (state)
      IDLE, OVER: begin
        if (start_edge) begin
          state_nx    = GAP;
          score_nx    = '0;
          phase_nx    = '0;
          sec_nx      = '0;
          time_nx     = TIME_INIT;
          has_prev_nx = 1'b0;
        end
      end
      GAP: begin
        if (phase_cnt == GAP_TICKS - 32'd1) begin
          phase_nx    = '0;
          idx_nx      = pick;
          has_prev_nx = 1'b1;
          state_nx    = SHOW;
        end else begin
          phase_nx = phase_cnt + 32'd1;
        end
      end
      SHOW: begin
`ifdef MOLE_MISS_PENALTY_EN
        if (!sw_evt[cur_idx] && (|sw_evt) && (score != '0)) begin
          score_nx = score - 1'b1;
        end
`endif
        // A hit wins over a timeout landing on the same cycle.
        if (sw_evt[cur_idx]) begin
          hit_nx   = 1'b1;
          if (score < SCORE_TOP) score_nx = score + 1'b1;
          phase_nx = '0;
          state_nx = GAP;
        end else if (phase_cnt == MOLE_TICKS - 32'd1) begin
          phase_nx = '0;
          state_nx = GAP;
        end else begin
          phase_nx = phase_cnt + 32'd1;
        end
      end
    endcase

    // End of game overrides any mole transition; a same-cycle hit is still scored.
    if (last_sec) state_nx = OVER;

    led_nx = (state_nx == SHOW) ? (ONE_HOT0 << idx_nx) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_cnt <= '0;
      sec_cnt   <= '0;
      cur_idx   <= '0;
      has_prev  <= 1'b0;
      score     <= '0;
      time_left <= TIME_INIT;
      led       <= '0;
      hit_pulse <= 1'b0;
      game_over <= 1'b0;
    end else begin
      phase_cnt <= phase_nx;
      sec_cnt   <= sec_nx;
      cur_idx   <= idx_nx;
      has_prev  <= has_prev_nx;
      score     <= score_nx;
      time_left <= time_nx;
      led       <= led_nx;
      hit_pulse <= hit_nx;
      game_over <= (state_nx == OVER);
    end
  end

endmodule

// File: tb/tb_mole_game_core.sv
// tb/tb_mole_game_core.sv - self-checking bench for mole_game_core
module tb_mole_game_core;

`ifdef MOLE_MISS_PENALTY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  localparam int K_HIT   = 0;
  localparam int K_MISS  = 1;
  localparam int K_WRONG = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [15:0] sw_a, sw_b;
  logic [15:0] led_a, led_b;
  logic [6:0]  score_a, score_b;
  logic [1:0]  tl_a;
  logic [6:0]  tl_b;
  logic        hp_a, hp_b, go_a, go_b;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mole_game_core #(
    .NUM_MOLES(16), .CLK_HZ(1000), .GAME_SECONDS(3), .MOLE_MS(100),
    .GAP_MS(20), .SCORE_MAX(99), .SCORE_W(7)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .sw(sw_a), .led(led_a),
    .score(score_a), .time_left(tl_a), .hit_pulse(hp_a), .game_over(go_a)
  );

  mole_game_core #(
    .NUM_MOLES(16), .CLK_HZ(1000), .GAME_SECONDS(99), .MOLE_MS(100),
    .GAP_MS(20), .SCORE_MAX(5), .SCORE_W(7)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .sw(sw_b), .led(led_b),
    .score(score_b), .time_left(tl_b), .hit_pulse(hp_b), .game_over(go_b)
  );

  typedef struct {
    int kind;
    int exp_score;
    int exp_pulse;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] led_of(input bit b);
    return b ? led_b : led_a;
  endfunction

  function automatic int idx_of(input logic [15:0] v);
    int r;
    r = 0;
    for (int k = 15; k >= 0; k--) if (v[k]) r = k;
    return r;
  endfunction

  task automatic toggle(input bit b, input int i);
    if (b) sw_b[i] = ~sw_b[i];
    else   sw_a[i] = ~sw_a[i];
  endtask

  task automatic wait_lit(input bit b);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (led_of(b) != 16'h0) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_lit", int'(ok), 1);
  endtask

  task automatic wait_dark(input bit b);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (led_of(b) == 16'h0) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_dark", int'(ok), 1);
  endtask

  task automatic full_game(input bit hit_last);
    int t2;
    int i;
    t2 = -1;
    start_a = 1'b0;
    repeat (4) tick();
    @(negedge clk) start_a = 1'b1;
    for (int c = 1; c <= 3010; c++) begin
      tick();
      if (t2 < 0 && tl_a == 2'd2) t2 = c;
      if (hit_last && c == 3000) begin
        i = idx_of(led_a);
        check("final_mole_lit", int'(led_a != 16'h0), 1);
        toggle(1'b0, i);
      end
      if (c == 3002) begin
        check("go_before_end", go_a, 0);
        check("tl_before_end", tl_a, 1);
      end
      if (c == 3003) begin
        check("go_at_end", go_a, 1);
        check("tl_at_end", tl_a, 0);
        check("score_at_end", score_a, hit_last ? 1 : 0);
        check("hp_at_end", hp_a, hit_last ? 1 : 0);
        check("led_at_end", led_a, 0);
      end
    end
    check("first_sec_tick", t2, 1003);
    check("go_held", go_a, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, i, j, e, cnt, prev, repeats, bad_hot;
    bit any_hp;

    tbl[0] = '{K_HIT,   1,       1};
    tbl[1] = '{K_HIT,   2,       1};
    tbl[2] = '{K_MISS,  2,       0};
    tbl[3] = '{K_WRONG, 2 - PEN, 0};
    tbl[4] = '{K_HIT,   3 - PEN, 1};
    tbl[5] = '{K_HIT,   4 - PEN, 1};
    tbl[6] = '{K_HIT,   5 - PEN, 1};
    tbl[7] = '{K_HIT,   5,       1};
    tbl[8] = '{K_HIT,   5,       1};

    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; sw_a = '0; sw_b = '0;
    repeat (3) tick();
    check("rst_led", led_a, 0);
    check("rst_score", score_a, 0);
    check("rst_time", tl_a, 3);
    check("rst_hp", hp_a, 0);
    check("rst_go", go_a, 0);
    @(negedge clk) reset = 1'b1;
    tick(); tick();

    // Start edge: 3-cycle latency, 20-cycle gap, then one mole.
    @(negedge clk) start_a = 1'b1;
    n = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (led_a != 16'h0) begin
        n = c;
        break;
      end
    end
    check("first_lit_cycle", n, 23);
    check("first_lit_onehot", $countones(led_a), 1);
    check("first_lit_time", tl_a, 3);

    // Hit 10 cycles into SHOW.
    repeat (10) tick();
    i = idx_of(led_a);
    @(negedge clk) toggle(1'b0, i);
    tick(); tick();
    check("hit_not_early", hp_a, 0);
    tick();
    check("hit_pulse", hp_a, 1);
    check("hit_score", score_a, 1);
    check("hit_led_dark", led_a, 0);
    tick();
    check("hit_pulse_1cyc", hp_a, 0);

    wait_lit(1'b0);
    i = idx_of(led_a);
    @(negedge clk) toggle(1'b0, i);
    repeat (3) tick();
    check("hit2_score", score_a, 2);

    // Wrong switches while a mole is lit.
    wait_lit(1'b0);
    repeat (10) tick();
    i = idx_of(led_a);
    j = (i + 1) % 16;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk) toggle(1'b0, j);
      repeat (3) tick();
      e = 2 - PEN * k;
      if (e < 0) e = 0;
      check("wrong_score", score_a, e);
      check("wrong_hp", hp_a, 0);
      check("wrong_still_lit", led_a, 1 << i);
    end

    // Reset mid-SHOW.
    check("pre_reset_lit", int'(led_a != 16'h0), 1);
    @(negedge clk) reset = 1'b0;
    #1;
    check("midrst_led", led_a, 0);
    check("midrst_score", score_a, 0);
    check("midrst_time", tl_a, 3);
    check("midrst_go", go_a, 0);
    start_a = 1'b0;
    tick();
    @(negedge clk) reset = 1'b1;
    any_hp = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (led_a != 16'h0) cnt++;
    end
    check("idle_after_rst_led", cnt, 0);
    check("idle_after_rst_time", tl_a, 3);

    full_game(1'b0);
    full_game(1'b1);

    // Table-driven sequence on the long-game, low-saturation instance.
    @(negedge clk) start_b = 1'b1;
    foreach (tbl[v]) begin
      wait_lit(1'b1);
      case (tbl[v].kind)
        K_HIT: begin
          repeat (10) tick();
          i = idx_of(led_b);
          @(negedge clk) toggle(1'b1, i);
          repeat (3) tick();
          check("tbl_hit_hp", hp_b, tbl[v].exp_pulse);
          check("tbl_hit_score", score_b, tbl[v].exp_score);
          check("tbl_hit_led", led_b, 0);
        end
        K_MISS: begin
          cnt = 1;
          any_hp = 1'b0;
          for (int c = 0; c < 300 && led_b != 16'h0; c++) begin
            tick();
            if (hp_b) any_hp = 1'b1;
            if (led_b != 16'h0) cnt++;
          end
          check("tbl_miss_lit_cycles", cnt, 100);
          check("tbl_miss_score", score_b, tbl[v].exp_score);
          check("tbl_miss_hp", int'(any_hp), tbl[v].exp_pulse);
        end
        default: begin
          repeat (10) tick();
          i = idx_of(led_b);
          @(negedge clk) toggle(1'b1, (i + 1) % 16);
          repeat (3) tick();
          check("tbl_wrong_score", score_b, tbl[v].exp_score);
          check("tbl_wrong_hp", hp_b, tbl[v].exp_pulse);
          check("tbl_wrong_lit", led_b, 1 << i);
          wait_dark(1'b1);
        end
      endcase
    end

    // 200 consecutive moles never repeat an index.
    prev = -1;
    repeats = 0;
    bad_hot = 0;
    n = checks - passes;
    for (int m = 0; m < 200; m++) begin
      wait_lit(1'b1);
      i = idx_of(led_b);
      if (i == prev) repeats++;
      if ($countones(led_b) != 1) bad_hot++;
      prev = i;
      toggle(1'b1, i);
      repeat (3) tick();
    end
    check("mole_repeats", repeats, 0);
    check("mole_onehot_bad", bad_hot, 0);
    check("b_score_sat", score_b, 5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
